// File: rtl/data_lsu_pkg.sv
// Shared types and helpers for the data load/store unit.
//   size_e       : access size encoding carried on cmd_size_i
//   state_e      : request/response sequencer states
//   lane_mask    : byte-lane mask of an access spanning two bus words
//   extend_load  : zero/sign extension of a right-aligned load result
package data_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'd0,
    SZ_HALF    = 2'd1,
    SZ_WORD    = 2'd2,
    SZ_ILLEGAL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  // Bits [3:0] are the lanes of the first word, bits [7:4] the lanes
  // of the following word; a non-zero upper nibble means the access splits.
  function automatic logic [7:0] lane_mask(input logic [1:0] offset, input size_e size);
    logic [7:0] base;
    case (size)
      SZ_BYTE: base = 8'h01;
      SZ_HALF: base = 8'h03;
      SZ_WORD: base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << offset;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] data, input size_e size,
                                              input logic sign_ext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = signed'(data[7:0]);
    h = signed'(data[15:0]);
    case (size)
      SZ_BYTE: r = sign_ext ? 32'(b) : {24'h0, data[7:0]};
      SZ_HALF: r = sign_ext ? 32'(h) : {16'h0, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_lsu_align.sv
// Combinational lane steering for data_lsu.
//   offset, size, sign_ext : access shape (addr[1:0], size, signed load)
//   part                   : 0 while handling the first bus word, 1 for the second
//   wdata                  : right-aligned store data
//   bus_rdata, ld_buf      : read data on the bus, bytes gathered from part 0
//   split                  : access crosses a word boundary
//   be0/wdata0, be1/wdata1 : byte enables and lane-aligned store data per part
//   ld_merged              : load bytes gathered so far, right-aligned
//   ld_ext                 : ld_merged trimmed and extended to 32 bits
module data_lsu_align
  import data_lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sign_ext,
  input  logic        part,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  input  logic [31:0] ld_buf,
  output logic        split,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] ld_merged,
  output logic [31:0] ld_ext
);

  logic [7:0] mask;
  logic [4:0] sh_lo;
  logic [5:0] sh_hi;

  always_comb begin
    mask   = lane_mask(offset, size);
    split  = |mask[7:4];
    be0    = mask[3:0];
    be1    = mask[7:4];
    sh_lo  = {offset, 3'b000};
    // Width of the bytes that landed in the first word; 32 when offset is
    // zero, which only occurs for unsplit accesses and shifts everything out.
    sh_hi  = 6'd32 - {1'b0, sh_lo};
    wdata0 = wdata << sh_lo;
    wdata1 = wdata >> sh_hi;
    // Part 0 leaves the upper offset bytes zero, so part 1 can simply OR in.
    ld_merged = part ? (ld_buf | (bus_rdata << sh_hi)) : (bus_rdata >> sh_lo);
    ld_ext    = extend_load(ld_merged, size, sign_ext);
  end

endmodule

// File: rtl/data_lsu.sv
// Load/store unit between a core command port and a req/gnt/rvalid data bus.
// Misaligned accesses are split into two word-aligned bus parts.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   cmd_*                : core command (valid/ready, we, size, signed, addr, wdata)
//   rsp_valid_o/rdata/err: one-cycle completion pulse with load data and error
//   data_*               : data bus request side and its gnt/rvalid/err/rdata
//   TIMEOUT              : cycles a part may wait for gnt/rvalid before aborting
module data_lsu
  import data_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_signed_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  input  logic [31:0] data_rdata_i
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e        state;
  logic [CW-1:0] cnt;

  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  size_e       cap_size;
  logic        cap_we;
  logic        cap_signed;
  logic [31:0] ld_buf;

  logic [1:0]  a_offset;
  size_e       a_size;
  logic        a_sign;
  logic [31:0] a_wdata;
  logic        a_part;
  logic        split;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, ld_merged, ld_ext;

  logic is_idle, in_req, in_wait, busy, accept, part_done, go_part1, timed_out;

  assign is_idle     = (state == ST_IDLE);
  assign cmd_ready_o = is_idle;

  always_comb begin
    in_req    = (state == ST_REQ0) || (state == ST_REQ1);
    in_wait   = (state == ST_WAIT0) || (state == ST_WAIT1);
    busy      = in_req || in_wait;
    a_part    = (state == ST_REQ1) || (state == ST_WAIT1);
    accept    = is_idle && cmd_valid_i;
    // Steer from the live command while idle so part 0 is ready on the
    // accepting edge; afterwards the captured command drives the lanes.
    a_offset  = is_idle ? cmd_addr_i[1:0] : cap_addr[1:0];
    a_size    = is_idle ? size_e'(cmd_size_i) : cap_size;
    a_sign    = is_idle ? cmd_signed_i : cap_signed;
    a_wdata   = is_idle ? cmd_wdata_i : cap_wdata;
    // Stores finish on gnt; loads need rvalid, either with gnt or later.
    part_done = in_req ? (data_gnt_i && (cap_we || data_rvalid_i))
                       : (in_wait && data_rvalid_i);
    go_part1  = busy && part_done && !data_err_i && !a_part && split;
    timed_out = (cnt == CW'(TIMEOUT - 1));
  end

  data_lsu_align u_align (
    .offset    (a_offset),
    .size      (a_size),
    .sign_ext  (a_sign),
    .part      (a_part),
    .wdata     (a_wdata),
    .bus_rdata (data_rdata_i),
    .ld_buf    (ld_buf),
    .split     (split),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ld_merged (ld_merged),
    .ld_ext    (ld_ext)
  );

  // Command capture and part-0 load bytes: data only, no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      cap_addr   <= cmd_addr_i;
      cap_wdata  <= cmd_wdata_i;
      cap_size   <= size_e'(cmd_size_i);
      cap_we     <= cmd_we_i;
      cap_signed <= cmd_signed_i;
    end
    if (go_part1 && !cap_we) ld_buf <= ld_merged;
  end

  // Sequencer with registered bus and response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_err_o    <= 1'b0;
      rsp_rdata_o  <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (size_e'(cmd_size_i) == SZ_ILLEGAL) begin
              state       <= ST_RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state        <= ST_REQ0;
              cnt          <= '0;
              data_req_o   <= 1'b1;
              data_we_o    <= cmd_we_i;
              data_addr_o  <= {cmd_addr_i[31:2], 2'b00};
              data_be_o    <= be0;
              data_wdata_o <= wdata0;
            end
          end
        end
        ST_REQ0, ST_WAIT0, ST_REQ1, ST_WAIT1: begin
          if (part_done) begin
            if (go_part1) begin
              state        <= ST_REQ1;
              cnt          <= '0;
              data_req_o   <= 1'b1;
              data_addr_o  <= data_addr_o + 32'd4;
              data_be_o    <= be1;
              data_wdata_o <= wdata1;
            end else begin
              state       <= ST_RESP;
              data_req_o  <= 1'b0;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= data_err_i;
              rsp_rdata_o <= (cap_we || data_err_i) ? 32'h0 : ld_ext;
            end
          end else if (timed_out) begin
            state       <= ST_RESP;
            data_req_o  <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (in_req && data_gnt_i) begin
              state      <= a_part ? ST_WAIT1 : ST_WAIT0;
              data_req_o <= 1'b0;
            end
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_lsu.sv
// Testbench for data_lsu: table of commands with bus timing knobs, a bus
// responder backed by a byte memory, a response scoreboard, and a reset
// sequence that abandons a load in WAIT0.
module tb_data_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_signed;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;

  always #5 clk = ~clk;

  data_lsu #(.TIMEOUT(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_size_i    (cmd_size),
    .cmd_signed_i  (cmd_signed),
    .cmd_addr_i    (cmd_addr),
    .cmd_wdata_i   (cmd_wdata),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_err_o     (rsp_err),
    .data_req_o    (data_req),
    .data_we_o     (data_we),
    .data_be_o     (data_be),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .data_gnt_i    (data_gnt),
    .data_rvalid_i (data_rvalid),
    .data_err_i    (data_err),
    .data_rdata_i  (data_rdata)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gw;         // REQ cycles before gnt
    logic        rvg;        // load: rvalid together with gnt
    int          rw;         // load, rvg=0: WAIT cycles before rvalid
    int          ep;         // part that reports data_err_i, -1 none
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_parts;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int          exp_lat;    // cycles from command presentation to rsp_valid
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic [7:0] mem [logic [31:0]];
  exp_t       sb[$];
  vec_t       vecs[18];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {rd_byte(a + 32'd3), rd_byte(a + 32'd2), rd_byte(a + 32'd1), rd_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_size    = 2'd0;
    cmd_signed  = 1'b0;
    cmd_addr    = 32'h0;
    cmd_wdata   = 32'h0;
    data_gnt    = 1'b0;
    data_rvalid = 1'b0;
    data_err    = 1'b0;
    data_rdata  = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          cyc, reqc, waitc, parts;
    bit          waiting, done;
    logic [31:0] wait_addr, ra, rwd, diff;
    logic [3:0]  rbe;
    exp_t        e;
    string       tag;
    cyc = 0; reqc = 0; waitc = 0; parts = 0; waiting = 0; done = 0;
    wait_addr = 0; ra = 0; rwd = 0; rbe = 0;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, "_ready"}, 32'(cmd_ready), 32'h1);
    cmd_valid  = 1'b1;
    cmd_we     = v.we;
    cmd_size   = v.size;
    cmd_signed = v.sgn;
    cmd_addr   = v.addr;
    cmd_wdata  = v.wdata;
    sb.push_back('{v.exp_rdata, v.exp_err, v.exp_lat});
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      idle_inputs();
      if (rsp_valid) begin
        done = 1;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_sb: response with empty scoreboard", tag);
        end else begin
          e = sb.pop_front();
          check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
          check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
          check({tag, "_rdata"}, rsp_rdata, e.rdata);
        end
        check({tag, "_req_in_resp"}, 32'(data_req), 32'h0);
      end else if (data_req) begin
        if (reqc == 0) begin
          parts++;
          ra = data_addr; rbe = data_be; rwd = data_wdata;
          check({tag, "_we"}, 32'(data_we), 32'(v.we));
          if (parts == 1) begin
            check({tag, "_addr0"}, data_addr, v.a0);
            check({tag, "_be0"}, 32'(data_be), 32'(v.be0));
            if (v.we) check({tag, "_wdata0"}, data_wdata, v.wd0);
          end else begin
            check({tag, "_addr1"}, data_addr, v.a1);
            check({tag, "_be1"}, 32'(data_be), 32'(v.be1));
            if (v.we) check({tag, "_wdata1"}, data_wdata, v.wd1);
          end
        end
        if (reqc == v.gw) begin
          if (v.gw > 0) begin
            diff = (data_addr ^ ra) | {28'h0, data_be ^ rbe} | (data_wdata ^ rwd);
            check({tag, "_stable"}, diff, 32'h0);
          end
          data_gnt = 1'b1;
          reqc = 0;
          if (v.we) begin
            for (int b = 0; b < 4; b++)
              if (data_be[b]) mem[data_addr + 32'(b)] = data_wdata[8*b +: 8];
            data_err = (v.ep == parts - 1);
          end else if (v.rvg) begin
            data_rvalid = 1'b1;
            data_rdata  = rd_word(data_addr);
            data_err    = (v.ep == parts - 1);
          end else begin
            waiting   = 1;
            waitc     = 0;
            wait_addr = data_addr;
          end
        end else begin
          reqc++;
        end
      end else if (waiting) begin
        if (waitc == v.rw) begin
          data_rvalid = 1'b1;
          data_rdata  = rd_word(wait_addr);
          data_err    = (v.ep == parts - 1);
          waiting     = 0;
        end else begin
          waitc++;
        end
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_done: no rsp_valid within 40 cycles", tag);
      sb.delete();
    end
    check({tag, "_parts"}, 32'(parts), 32'(v.exp_parts));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit resp_seen;
    // memory 0x0FC..0x103 = 11 22 33 44 55 66 77 88
    for (int i = 0; i < 8; i++) mem[32'h0FC + 32'(i)] = 8'(8'h11 * (i + 1));

    //            we    sz    sgn   addr          wdata         gw rvg  rw ep  exp_rdata     err  np a0            be0   wd0           a1            be1   wd1           lat
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h00000100, 32'hDEADBEEF, 0, 1'b0, 0, -1, 32'h00000000, 1'b0, 1, 32'h00000100, 4'hF, 32'hDEADBEEF, 32'h0,        4'h0, 32'h0,        2};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,        2, 1'b0, 1, -1, 32'hDEADBEEF, 1'b0, 1, 32'h00000100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        6};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h00000103, 32'h00000080, 1, 1'b0, 0, -1, 32'h00000000, 1'b0, 1, 32'h00000100, 4'h8, 32'h80000000, 32'h0,        4'h0, 32'h0,        3};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h00000103, 32'h0,        0, 1'b1, 0, -1, 32'hFFFFFF80, 1'b0, 1, 32'h00000100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        2};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h00000103, 32'h0,        0, 1'b0, 0, -1, 32'h00000080, 1'b0, 1, 32'h00000100, 4'h8, 32'h0,        32'h0,        4'h0, 32'h0,        3};
    vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h00000100, 32'h88776655, 0, 1'b0, 0, -1, 32'h00000000, 1'b0, 1, 32'h00000100, 4'hF, 32'h88776655, 32'h0,        4'h0, 32'h0,        2};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h000000FE, 32'h0,        0, 1'b1, 0, -1, 32'h66554433, 1'b0, 2, 32'h000000FC, 4'hC, 32'h0,        32'h00000100, 4'h3, 32'h0,        3};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h000000FF, 32'h0,        1, 1'b0, 2, -1, 32'h00005544, 1'b0, 2, 32'h000000FC, 4'h8, 32'h0,        32'h00000100, 4'h1, 32'h0,        11};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h00000102, 32'h0,        0, 1'b1, 0, -1, 32'hFFFF8877, 1'b0, 1, 32'h00000100, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        2};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000A1B2, 0, 1'b0, 0, -1, 32'h00000000, 1'b0, 2, 32'hFFFFFFFC, 4'h8, 32'hB2000000, 32'h00000000, 4'h1, 32'h000000A1, 3};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,        1, 1'b1, 0, -1, 32'h0000A1B2, 1'b0, 2, 32'hFFFFFFFC, 4'h8, 32'h0,        32'h00000000, 4'h1, 32'h0,        5};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 32'h00000100, 32'h0,        0, 1'b1, 0, -1, 32'h00000000, 1'b1, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        1};
    vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h00000101, 32'h12345678, 0, 1'b0, 0, -1, 32'h00000000, 1'b0, 2, 32'h00000100, 4'hE, 32'h34567800, 32'h00000104, 4'h1, 32'h00000012, 3};
    vecs[13] = '{1'b0, 2'd2, 1'b1, 32'h00000101, 32'h0,        0, 1'b0, 0, -1, 32'h12345678, 1'b0, 2, 32'h00000100, 4'hE, 32'h0,        32'h00000104, 4'h1, 32'h0,        5};
    vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0,       99, 1'b1, 0, -1, 32'h00000000, 1'b1, 1, 32'h00000100, 4'hF, 32'h0,        32'h0,        4'h0, 32'h0,        17};
    vecs[15] = '{1'b0, 2'd2, 1'b0, 32'h000000FE, 32'h0,        0, 1'b1, 0,  0, 32'h00000000, 1'b1, 1, 32'h000000FC, 4'hC, 32'h0,        32'h0,        4'h0, 32'h0,        2};
    vecs[16] = '{1'b1, 2'd1, 1'b0, 32'h000000FF, 32'h0000CAFE, 0, 1'b0, 0,  0, 32'h00000000, 1'b1, 1, 32'h000000FC, 4'h8, 32'hFE000000, 32'h0,        4'h0, 32'h0,        2};
    vecs[17] = '{1'b0, 2'd2, 1'b0, 32'h000000FF, 32'h0,        0, 1'b1, 0,  1, 32'h00000000, 1'b1, 2, 32'h000000FC, 4'h8, 32'h0,        32'h00000100, 4'h7, 32'h0,        3};

    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_data_req", 32'(data_req), 32'h0);
    check("rst_data_we", 32'(data_we), 32'h0);
    check("rst_data_be", 32'(data_be), 32'h0);
    check("rst_data_addr", data_addr, 32'h0);
    check("rst_data_wdata", data_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Reset while a load waits for rvalid, then stray rvalid/gnt.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_size = 2'd2; cmd_addr = 32'h100;
    @(negedge clk);
    idle_inputs();
    check("rs_req0", 32'(data_req), 32'h1);
    data_gnt = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("rs_wait0_req", 32'(data_req), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rs_ready_after_rst", 32'(cmd_ready), 32'h1);
    check("rs_req_after_rst", 32'(data_req), 32'h0);
    resp_seen = 1'b0;
    if (rsp_valid) resp_seen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_rvalid = 1'b1;
      data_gnt    = 1'(i % 2);
      data_rdata  = 32'hFFFFFFFF;
      @(negedge clk);
      if (rsp_valid) resp_seen = 1'b1;
    end
    idle_inputs();
    check("rs_no_rsp", 32'(resp_seen), 32'h0);
    check("rs_still_idle", 32'(cmd_ready), 32'h1);
    check("rs_no_req", 32'(data_req), 32'h0);

    run_vec(100, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_lsu.md
DATA_LSU -- requirements
Module: data_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles spent waiting for data_gnt_i or data_rvalid_i before aborting.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  clock, rising edge; rst_i  input  1  synchronous active-high reset.
REQ-003 cmd_valid_i  input  1  core command valid; cmd_ready_o  output  1  command accepted when both high.
REQ-004 cmd_we_i  input  1  1=store; cmd_size_i  input  2  0=byte, 1=half, 2=word, 3=illegal; cmd_signed_i  input  1  sign-extend load result.
REQ-005 cmd_addr_i  input  32  byte address; cmd_wdata_i  input  32  store data, right-aligned.
REQ-006 rsp_valid_o  output  1  one-cycle completion pulse; rsp_rdata_o  output  32  extended load data; rsp_err_o  output  1  bus error, timeout or illegal size.
REQ-007 data_req_o, data_we_o  output  1 each; data_be_o  output  4; data_addr_o, data_wdata_o  output  32; data_gnt_i, data_rvalid_i, data_err_i  input  1 each; data_rdata_i  input  32.

Function
REQ-008 cmd_ready_o SHALL be high only in IDLE; the command is captured on the accepting edge.
REQ-009 The FSM SHALL have states IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE->REQ0 on accept with a legal size.
- IDLE->RESP with rsp_err_o=1 on accept with size 3; no bus activity.
REQ-010 In REQ0/REQ1, data_req_o SHALL be 1. data_addr_o, data_be_o, data_we_o and data_wdata_o SHALL stay stable until data_gnt_i is sampled high.
REQ-011 data_addr_o SHALL be word-aligned ({addr[31:2],2'b00}).
- Part 0: data_be_o = lane mask for bytes o..min(o+n-1,3), where o=addr[1:0] and n=1<<size.
- data_wdata_o = cmd_wdata shifted left 8*o.
REQ-012 An access SHALL be split when o+n>4.
- Part 1 uses address part0+4; the address wraps 0xFFFFFFFC->0x00000000.
- Part 1 uses data_be_o=(1<<(o+n-4))-1 and data_wdata_o=cmd_wdata>>8*(4-o).
REQ-013 Store completion: the gnt cycle SHALL complete the part, and data_err_i SHALL be sampled in the same cycle.
- Next state: REQ1 if split and no error, else RESP.
REQ-014 Load handling: gnt moves REQx->WAITx. If data_rvalid_i is high in the gnt cycle, the part completes immediately; otherwise completion waits in WAITx for rvalid.
- data_rdata_i and data_err_i SHALL be sampled on rvalid.
REQ-015 Load assembly:
- Part 0 bytes SHALL fill result[8*(4-o)-1:0] from rdata>>8*o.
- Part 1 bytes SHALL fill the bytes above them.
- Bytes beyond n SHALL then be zeroed, or sign-extended from bit 8n-1 when cmd_signed_i=1.
REQ-016 RESP SHALL drive rsp_valid_o=1 for exactly one cycle, then return to IDLE.
- rsp_rdata_o SHALL be 0 for stores and errored loads.
- Best case: accept edge, REQ0 with gnt+rvalid, RESP; rsp_valid_o rises 2 cycles after accept.
REQ-017 Timeout: a counter SHALL clear on entering REQx and increment each cycle in REQx/WAITx. When it reaches TIMEOUT-1 without completion, the FSM SHALL go to RESP with rsp_err_o=1.
- data_req_o SHALL drop in RESP.
REQ-018 An error in part 0 SHALL skip part 1; part-0 store bytes already written are not rolled back.
REQ-019 data_rvalid_i arriving in IDLE, REQx or RESP SHALL be ignored; data_gnt_i outside REQx SHALL be ignored.

Reset
REQ-020 With rst_i high at a rising edge, on the next cycle:
- FSM = IDLE, counter = 0.
- cmd_ready_o=1; rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
- data_req_o=0, data_we_o=0, data_be_o=0, data_addr_o=0, data_wdata_o=0.
REQ-021 Reset mid-transaction SHALL abandon it without a response pulse; a late rvalid SHALL be ignored per REQ-019.

Structure
REQ-022 Package data_lsu_pkg SHALL hold:
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
- the state enum;
- the lane-mask and extension functions.
REQ-023 Combinational sub-module data_lsu_align SHALL compute be/wdata per part and the load merge/extension. The FSM, counter and capture registers SHALL stay in data_lsu.

Verification
REQ-024 Aligned store, word 0xDEADBEEF @0x100, gnt same cycle as req:
- bus shows be=1111, addr=0x100, wdata=0xDEADBEEF;
- rsp_valid_o 2 cycles after accept, rsp_err_o=0.
REQ-025 Signed byte load @0x103, memory byte 0x80, rvalid with gnt:
- be=1000, addr=0x100;
- rsp_rdata_o=0xFFFFFF80; unsigned load gives 0x00000080.
REQ-026 Misaligned word load @0x0FE, memory 0x0FC..0x103 = 11 22 33 44 55 66 77 88:
- part 0: addr 0x0FC, be 1100; part 1: addr 0x100, be 0011;
- rsp_rdata_o=0x66554433.
REQ-027 Misaligned half store @0xFFFFFFFF, data 0xA1B2:
- part 0: addr 0xFFFFFFFC, be 1000, wdata[31:24]=0xB2;
- part 1: addr 0x00000000, be 0001, wdata[7:0]=0xA1.
REQ-028 Load with gnt withheld for 16 cycles (TIMEOUT=16):
- rsp_valid_o=1, rsp_err_o=1, data_req_o=0 after the abort;
- repeat with data_err_i=1 on part 0 of a split access: no part 1 request issued.
REQ-029 Reset asserted in WAIT0, then rvalid pulsed:
- no rsp_valid_o;
- cmd_ready_o=1 on the cycle after reset.
